// File: rtl/gmii_rx_monitor.sv
// GMII receive-path checker: forwards the byte stream with a 2-cycle lag and marks bad frames.
// Statistics counters exist only when GMII_RX_MON_STATS_EN is defined.
module gmii_rx_monitor #(
   parameter int MIN_LEN   = 64,
   parameter int MAX_LEN   = 1522,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_dv,
   input  logic                 rx_er,
   output logic [7:0]           tx_data,
   output logic                 tx_en,
   output logic                 tx_er,
   input  logic                 cnt_clr,
   output logic                 frame_done,
   output logic                 frame_ok,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] crc_err_cnt,
   output logic [CNT_WIDTH-1:0] len_err_cnt,
   output logic [CNT_WIDTH-1:0] sfd_err_cnt
);

   typedef enum logic [2:0] {IDLE, PRE, DATA, BADPRE, SKIP} state_t;

   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L       = 11'(MAX_LEN);

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [10:0] len_sat_inc(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   state_t      state_q;
   logic        post_rst_q;
   logic [31:0] crc_q;
   logic [10:0] len_q;
   logic        er_seen_q;

   logic [7:0]  dat_p1_q;
   logic        dv_p1_q;
   logic        er_p1_q;

   logic [7:0]  tx_data_q;
   logic        tx_en_q;
   logic        tx_er_q;
   logic        frame_done_q;
   logic        frame_ok_q;

   logic        skip_d;
   logic        last_p1_d;
   logic        sfd_bad_d;
   logic        len_bad_d;
   logic        crc_bad_d;
   logic        bad_d;
   logic [31:0] crc_d;

   // The byte in stage 1 is the frame's last one when the incoming rx_dv has dropped;
   // the frame verdict is formed in that same cycle from the fully updated CRC/length.
   always_comb begin
      skip_d    = (state_q == SKIP) || ((state_q == IDLE) && post_rst_q);
      last_p1_d = dv_p1_q && !rx_dv;
      crc_d     = crc32_byte(crc_q, rx_data);
      sfd_bad_d = (state_q != DATA);
      len_bad_d = !sfd_bad_d && ((len_q < MIN_L) || (len_q > MAX_L));
      crc_bad_d = !sfd_bad_d && !len_bad_d && ((crc_q != CRC_RESIDUE) || er_seen_q);
      bad_d     = sfd_bad_d || len_bad_d || crc_bad_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         post_rst_q <= 1'b1;
         crc_q      <= 32'hFFFFFFFF;
         len_q      <= 11'd0;
         er_seen_q  <= 1'b0;
      end else begin
         post_rst_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rx_dv) begin
                  if (post_rst_q) begin
                     state_q <= SKIP;
                  end else begin
                     er_seen_q <= rx_er;
                     if (rx_data == 8'hD5) begin
                        state_q <= DATA;
                        crc_q   <= 32'hFFFFFFFF;
                        len_q   <= 11'd0;
                     end else if (rx_data == 8'h55) begin
                        state_q <= PRE;
                     end else begin
                        state_q <= BADPRE;
                     end
                  end
               end
            end
            PRE: begin
               if (!rx_dv) begin
                  state_q <= IDLE;
               end else begin
                  er_seen_q <= er_seen_q | rx_er;
                  if (rx_data == 8'hD5) begin
                     state_q <= DATA;
                     crc_q   <= 32'hFFFFFFFF;
                     len_q   <= 11'd0;
                  end else if (rx_data != 8'h55) begin
                     state_q <= BADPRE;
                  end
               end
            end
            DATA: begin
               if (!rx_dv) begin
                  state_q <= IDLE;
               end else begin
                  crc_q     <= crc_d;
                  len_q     <= len_sat_inc(len_q);
                  er_seen_q <= er_seen_q | rx_er;
               end
            end
            BADPRE: begin
               if (!rx_dv) state_q <= IDLE;
               else        er_seen_q <= er_seen_q | rx_er;
            end
            SKIP: begin
               if (!rx_dv) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stage 1 / stage 2 boundary: stage 2 drives the outputs directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         dat_p1_q     <= 8'd0;
         dv_p1_q      <= 1'b0;
         er_p1_q      <= 1'b0;
         tx_data_q    <= 8'd0;
         tx_en_q      <= 1'b0;
         tx_er_q      <= 1'b0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
      end else begin
         dat_p1_q     <= rx_data;
         dv_p1_q      <= rx_dv && !skip_d;
         er_p1_q      <= rx_er;
         tx_data_q    <= dat_p1_q;
         tx_en_q      <= dv_p1_q;
         tx_er_q      <= er_p1_q || (last_p1_d && bad_d);
         frame_done_q <= last_p1_d;
         frame_ok_q   <= last_p1_d && !bad_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_en      = tx_en_q;
   assign tx_er      = tx_er_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;

`ifdef GMII_RX_MON_STATS_EN
   function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   logic                 ev_sfd_q;
   logic                 ev_len_q;
   logic                 ev_crc_q;
   logic [CNT_WIDTH-1:0] frame_cnt_q;
   logic [CNT_WIDTH-1:0] crc_err_cnt_q;
   logic [CNT_WIDTH-1:0] len_err_cnt_q;
   logic [CNT_WIDTH-1:0] sfd_err_cnt_q;

   // Verdict class is registered alongside frame_done, so counters move one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_sfd_q      <= 1'b0;
         ev_len_q      <= 1'b0;
         ev_crc_q      <= 1'b0;
         frame_cnt_q   <= '0;
         crc_err_cnt_q <= '0;
         len_err_cnt_q <= '0;
         sfd_err_cnt_q <= '0;
      end else begin
         ev_sfd_q <= last_p1_d && sfd_bad_d;
         ev_len_q <= last_p1_d && len_bad_d;
         ev_crc_q <= last_p1_d && crc_bad_d;
         if (cnt_clr) begin
            frame_cnt_q   <= '0;
            crc_err_cnt_q <= '0;
            len_err_cnt_q <= '0;
            sfd_err_cnt_q <= '0;
         end else if (frame_done_q) begin
            if (frame_ok_q) frame_cnt_q   <= cnt_sat_inc(frame_cnt_q);
            if (ev_crc_q)   crc_err_cnt_q <= cnt_sat_inc(crc_err_cnt_q);
            if (ev_len_q)   len_err_cnt_q <= cnt_sat_inc(len_err_cnt_q);
            if (ev_sfd_q)   sfd_err_cnt_q <= cnt_sat_inc(sfd_err_cnt_q);
         end
      end
   end

   assign frame_cnt   = frame_cnt_q;
   assign crc_err_cnt = crc_err_cnt_q;
   assign len_err_cnt = len_err_cnt_q;
   assign sfd_err_cnt = sfd_err_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign frame_cnt      = '0;
   assign crc_err_cnt    = '0;
   assign len_err_cnt    = '0;
   assign sfd_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_monitor.sv
// Bench for gmii_rx_monitor: frame-level reference model plus directed frames.
module tb_gmii_rx_monitor;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef GMII_RX_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_dv = 1'b0;
   logic          rx_er = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_en, tx_er, frame_done, frame_ok;
   logic [CW-1:0] frame_cnt, crc_err_cnt, len_err_cnt, sfd_err_cnt;

   gmii_rx_monitor #(.MIN_LEN(64), .MAX_LEN(1522), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
      .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er), .cnt_clr(cnt_clr),
      .frame_done(frame_done), .frame_ok(frame_ok), .frame_cnt(frame_cnt),
      .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt), .sfd_err_cnt(sfd_err_cnt)
   );

   always #5 clk = ~clk;

   // cls: 0 none, 1 good, 2 crc error, 3 length error, 4 sfd error
   typedef struct {
      logic [7:0] d;
      logic       en, er, done, ok, clr, rs, zero;
      int         cls;
   } rec_t;

   rec_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         m_cnt[5];
   logic [7:0] frm_buf[$];
   logic [7:0] mdl_frm[$];
   logic       mdl_er = 1'b0;
   bit         in_frame = 1'b0;
   bit         skipping = 1'b0;
   bit         prev_rst = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] crc_calc(input logic [7:0] f[$], input int lo, input int hi);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int k = lo; k < hi; k++) begin
         c = c ^ {24'd0, f[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Frame verdict from the whole byte list: preamble shape, length after SFD, then FCS.
   function automatic int classify(input logic [7:0] f[$], input logic er);
      int          i, n, len;
      logic [31:0] fcs, c;
      n = f.size();
      i = 0;
      while (i < n && f[i] == 8'h55) i++;
      if (i >= n || f[i] != 8'hD5) return 4;
      len = n - i - 1;
      if (len < 64 || len > 1522) return 3;
      c   = ~crc_calc(f, i + 1, n - 4);
      fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
      if (er || c != fcs) return 2;
      return 1;
   endfunction

   task automatic build(input int npre, input int len);
      logic [31:0] c;
      frm_buf.delete();
      for (int k = 0; k < npre; k++) frm_buf.push_back(8'h55);
      frm_buf.push_back(8'hD5);
      for (int k = 0; k < len - 4; k++) frm_buf.push_back(8'((k * 37 + len) & 255));
      c = ~crc_calc(frm_buf, npre + 1, frm_buf.size());
      frm_buf.push_back(c[7:0]);
      frm_buf.push_back(c[15:8]);
      frm_buf.push_back(c[23:16]);
      frm_buf.push_back(c[31:24]);
   endtask

   task automatic drive(input logic [7:0] d, input logic dv, input logic er,
                        input logic clr, input logic r);
      rec_t rec, t;
      int   c;
      @(posedge clk);
      #1;
      rx_data = d; rx_dv = dv; rx_er = er; cnt_clr = clr; rst = r;
      rec.d = d; rec.en = dv; rec.er = er; rec.done = 1'b0; rec.ok = 1'b0;
      rec.clr = clr; rec.rs = r; rec.zero = r; rec.cls = 0;
      if (r) begin
         if (exp_q.size() > 0) begin
            t = exp_q[exp_q.size()-1];
            t.zero = 1'b1;
            exp_q[exp_q.size()-1] = t;
         end
         in_frame = 1'b0; skipping = 1'b0; prev_rst = 1'b1;
      end else begin
         if (prev_rst && dv) skipping = 1'b1;
         prev_rst = 1'b0;
         if (skipping) begin
            if (dv) rec.en = 1'b0;
            else    skipping = 1'b0;
         end else if (dv) begin
            if (!in_frame) begin
               in_frame = 1'b1;
               mdl_frm.delete();
               mdl_er = 1'b0;
            end
            mdl_frm.push_back(d);
            mdl_er = mdl_er | er;
         end else if (in_frame) begin
            in_frame = 1'b0;
            c = classify(mdl_frm, mdl_er);
            t = exp_q[exp_q.size()-1];
            t.done = 1'b1;
            t.ok   = (c == 1);
            t.cls  = c;
            if (c != 1) t.er = 1'b1;
            exp_q[exp_q.size()-1] = t;
         end
      end
      exp_q.push_back(rec);
   endtask

   task automatic send(input int er_at, input int gap, input bit clr_hit);
      for (int k = 0; k < frm_buf.size(); k++) drive(frm_buf[k], 1'b1, 1'(k == er_at), 1'b0, 1'b0);
      for (int g = 0; g < gap; g++) drive(8'h00, 1'b0, 1'b0, 1'(clr_hit && g == 1), 1'b0);
   endtask

   // Output checker: one stream comparison and one counter comparison per cycle.
   initial begin
      rec_t        r, nx;
      int          pend;
      logic [31:0] act, want;
      pend = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() >= 3) begin
            nx = exp_q[1];
            if (nx.rs || nx.clr) begin
               for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            end else if (STATS && pend != 0 && m_cnt[pend] < CMAX) begin
               m_cnt[pend]++;
            end
            pend = 0;
            r    = exp_q.pop_front();
            want = r.zero ? 32'd0 : 32'({r.er, r.en, r.d, r.done, r.ok});
            act  = 32'({tx_er, tx_en, tx_data, frame_done, frame_ok});
            check("stream", act, want);
            act  = 32'({frame_cnt, crc_err_cnt, len_err_cnt, sfd_err_cnt});
            want = 32'({CW'(m_cnt[1]), CW'(m_cnt[2]), CW'(m_cnt[3]), CW'(m_cnt[4])});
            check("counters", act, want);
            if (!r.zero && r.done) pend = r.cls;
         end
      end
   end

   initial begin
      logic [7:0] q9[$];
      for (int k = 0; k < 9; k++) q9.push_back(8'(8'h31 + k));
      check("crc_model_pin", ~crc_calc(q9, 0, 9), 32'hCBF43926);

      for (int k = 0; k < 3; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_out", 32'({tx_er, tx_en, tx_data, frame_done, frame_ok}), 32'd0);
      check("reset_cnt", 32'({frame_cnt, crc_err_cnt, len_err_cnt, sfd_err_cnt}), 32'd0);

      build(7, 64);
      check("cls_good_pin", 32'(classify(frm_buf, 1'b0)), 32'd1);
      send(-1, 12, 1'b0);
      check("frame_cnt_good", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);

      frm_buf[8 + 20] = frm_buf[8 + 20] ^ 8'h01;
      check("cls_crc_pin", 32'(classify(frm_buf, 1'b0)), 32'd2);
      send(-1, 12, 1'b0);
      check("crc_err_corrupt", 32'(crc_err_cnt), STATS ? 32'd1 : 32'd0);

      build(7, 64);
      send(40, 12, 1'b0);
      check("crc_err_rxer", 32'(crc_err_cnt), STATS ? 32'd2 : 32'd0);

      build(7, 60);
      check("cls_runt_pin", 32'(classify(frm_buf, 1'b0)), 32'd3);
      send(-1, 12, 1'b0);
      check("len_err_runt", 32'(len_err_cnt), STATS ? 32'd1 : 32'd0);
      build(7, 1523);
      send(-1, 12, 1'b0);
      check("len_err_giant", 32'(len_err_cnt), STATS ? 32'd2 : 32'd0);
      build(7, 1522);
      send(-1, 12, 1'b0);
      check("frame_cnt_max", 32'(frame_cnt), STATS ? 32'd2 : 32'd0);

      build(7, 64);
      frm_buf[1] = 8'h54;
      send(-1, 12, 1'b0);
      check("sfd_err_pre", 32'(sfd_err_cnt), STATS ? 32'd1 : 32'd0);
      check("crc_unchanged", 32'(crc_err_cnt), STATS ? 32'd2 : 32'd0);
      build(0, 64);
      send(-1, 12, 1'b0);
      check("frame_cnt_sfd_only", 32'(frame_cnt), STATS ? 32'd3 : 32'd0);

      for (int k = 0; k < 3; k++) drive(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("clr_cnt", 32'(frame_cnt), 32'd0);

      build(1, 64);
      for (int n = 0; n < 17; n++) send(-1, 1, 1'b0);
      for (int k = 0; k < 6; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("frame_cnt_sat", 32'(frame_cnt), STATS ? 32'd15 : 32'd0);

      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send(-1, 8, 1'b0);
      check("frame_cnt_one", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
      send(-1, 8, 1'b1);
      check("clr_priority", 32'(frame_cnt), 32'd0);

      build(7, 64);
      for (int k = 0; k < frm_buf.size(); k++) drive(frm_buf[k], 1'b1, 1'b0, 1'b0, 1'(k == 30));
      for (int k = 0; k < 12; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_mid_cnt", 32'({frame_cnt, crc_err_cnt, len_err_cnt, sfd_err_cnt}), 32'd0);
      send(-1, 12, 1'b0);
      check("frame_cnt_after_rst", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);

      for (int k = 0; k < 5; k++) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gmii_rx_monitor.md
Name: gmii_rx_monitor

Overview:
- In-line GMII receive-path checker placed between each port's 2-stage register slice and its packet FIFO; one instance per PHY receive path.
- Forwards the byte stream with a fixed 2-cycle latency.
- Validates preamble/SFD, frame length and Ethernet FCS. Flags bad frames by asserting tx_er on the frame's last byte.
- Keeps saturating per-port statistics for the controller.

Parameters:
- MIN_LEN, 64: minimum legal frame bytes after SFD, FCS included.
- MAX_LEN, 1522: maximum legal frame bytes after SFD, FCS included.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  receive clock of the port; one byte per cycle while rx_dv high.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  GMII receive data.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- tx_data  out  8  forwarded data.
- tx_en  out  1  forwarded valid.
- tx_er  out  1  forwarded error, plus bad-frame mark.
- cnt_clr  in  1  synchronous clear of all counters.
- frame_done  out  1  one-cycle pulse on the last forwarded byte of any frame.
- frame_ok  out  1  one-cycle pulse with frame_done when the frame is good.
- frame_cnt  out  CNT_WIDTH  good frames.
- crc_err_cnt  out  CNT_WIDTH  frames with bad FCS.
- len_err_cnt  out  CNT_WIDTH  runt or giant frames.
- sfd_err_cnt  out  CNT_WIDTH  frames with bad or missing preamble/SFD.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset values:
  - tx_data=0, tx_en=0, tx_er=0, frame_done=0, frame_ok=0.
  - All counters 0; FSM in IDLE; both pipeline stages cleared.
- Datapath: {tx_er,tx_en,tx_data} equals {rx_er,rx_dv,rx_data} delayed exactly 2 cycles, except for the bad-frame mark below.
- Frame boundaries:
  - A frame is a maximal run of rx_dv=1.
  - Its last byte is the byte whose following rx_dv is 0. The 2-cycle delay lets this be known when the byte reaches stage 2.
- FSM:
  - IDLE: rx_dv=1 with byte 0xD5 -> DATA; with 0x55 -> PRE; any other byte -> BADPRE.
  - PRE: 0x55 stays in PRE; 0xD5 -> DATA; other byte -> BADPRE; rx_dv=0 -> IDLE, counted as an SFD error.
  - DATA: the byte after SFD starts the length count and the CRC; rx_dv=0 -> IDLE, frame evaluated.
  - BADPRE: consumes bytes until rx_dv=0 -> IDLE, counted as an SFD error.
  - SKIP: entered out of reset if rx_dv=1; tx_en is held 0 until rx_dv=0 -> IDLE. The partial frame is not forwarded and not counted.
- Length: 11-bit counter saturating at 2047 counts bytes after SFD.
  - Runt if length < MIN_LEN.
  - Giant if length > MAX_LEN.
- CRC: reflected CRC-32 (poly 0x04C11DB7), init 0xFFFFFFFF, run over all bytes after SFD including FCS. Good if the final register equals 0xDEBB20E3.
- Evaluation priority (exactly one counter increments per frame): SFD error > length error > CRC error or rx_er seen in-frame (counted as CRC error) > good.
- Bad-frame mark: for any bad frame, tx_er=1 on the last forwarded byte. Other bytes carry the delayed rx_er unchanged.
- rx_dv=0 with rx_er=1 (false carrier or extension) is forwarded unchanged and not counted.
- Back-to-back frames with a 1-cycle gap are handled: IDLE re-enters on the next rx_dv.
- Counters:
  - Saturate at all-ones.
  - cnt_clr takes priority over a same-cycle increment (result 0).
  - Counters update the cycle after frame_done.

Optional Feature:
- Macro GMII_RX_MON_STATS_EN.
- Defined: the four counters and cnt_clr operate as specified.
- Undefined: counter logic is removed, all four counter outputs are tied to 0 and cnt_clr is ignored. Forwarding, tx_er marking, frame_done and frame_ok are unchanged.

Test Plan:
- Good frame: preamble 7×0x55 + 0xD5, 64 bytes with valid FCS -> tx stream identical with 2-cycle lag; tx_er=0; frame_done=frame_ok=1 on the last byte; frame_cnt=1.
- Corrupted byte: same frame with byte 20 XOR 0x01 -> tx_er=1 only on the last byte; frame_ok=0; crc_err_cnt=1. Separately, rx_er=1 for one in-frame cycle -> crc_err_cnt=1.
- Length errors: 60-byte frame with valid FCS -> len_err_cnt=1 and tx_er on the last byte; 1523-byte frame -> len_err_cnt=2; 1522-byte frame -> frame_cnt increments.
- Bad preamble: preamble 0x55,0x54,0x55,…,0xD5 -> sfd_err_cnt=1, crc_err_cnt unchanged; frame with SFD only (no 0x55) and valid FCS -> good.
- Saturation: CNT_WIDTH=4, 17 good frames -> frame_cnt=15; cnt_clr pulsed on the same cycle as an increment -> 0.
- Reset mid-frame: rst pulsed at byte 30 of a frame -> tx_en=0 until rx_dv drops and no counter changes; next frame passes and frame_cnt=1.
